// File: rtl/coherence_bus_ctrl.sv
// N-CPU coherence/memory arbiter: round-robin icache/dcache access to one RAM
// port with MSI snooping and cache-to-cache forwarding.

module coherence_bus_lane #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_done,
  input  logic              data_done,
  input  logic              data_take,
  input  logic              snoop,
  input  logic              inv,
  input  logic              snoop_end,
  input  logic [WORD_W-1:0] ram_data,
  input  logic [WORD_W-1:0] load_data,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ccwait,
  output logic              ccinv,
  output logic              ccdone,
  output logic [WORD_W-1:0] ccsnoopaddr
);
  logic [WORD_W-1:0] iload_q, dload_q;

  // load buses present fresh data in the completion cycle and hold it afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      if (fetch_done) iload_q <= ram_data;
      if (data_take)  dload_q <= load_data;
    end
  end

  assign iwait       = ~fetch_done;
  assign dwait       = ~data_done;
  assign iload       = fetch_done ? ram_data : iload_q;
  assign dload       = data_take ? load_data : dload_q;
  assign ccwait      = snoop;
  assign ccinv       = snoop & inv;
  assign ccdone      = snoop_end;
  assign ccsnoopaddr = snoop ? snoop_addr : '0;
endmodule

module coherence_bus_ctrl #(
  parameter int CPUS         = 2,
  parameter int WORD_W       = 32,
  parameter int SNOOP_CYCLES = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic [CPUS-1:0]        ccdone,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  output logic                   ramREN,
  output logic                   ramWEN
);
  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [2:0] CNT_LAST = 3'(SNOOP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WB, SNOOP, RESP, C2C, DREAD, IFETCH} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   r, r_n, own, own_n, dptr, dptr_n, iptr, iptr_n;
  logic [2:0]      cnt, cnt_n;
  logic            snooped, snooped_n, acc, snoop_on;

  logic [WORD_W-1:0] ia [CPUS];
  logic [WORD_W-1:0] da [CPUS];
  logic [WORD_W-1:0] ds [CPUS];

  logic [CPUS-1:0]   fetch_done, data_done, data_take, snoop, snoop_end;
  logic [WORD_W-1:0] load_data;

  function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] w;
    logic hit;
    int idx;
    w   = ptr;
    hit = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      idx = (int'(ptr) + i) % CPUS;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        w   = IW'(idx);
      end
    end
    return w;
  endfunction

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (int'(x) == CPUS - 1) ? '0 : x + 1'b1;
  endfunction

  for (genvar g = 0; g < CPUS; g++) begin : g_unpack
    assign ia[g] = iaddr[g*WORD_W +: WORD_W];
    assign da[g] = daddr[g*WORD_W +: WORD_W];
    assign ds[g] = dstore[g*WORD_W +: WORD_W];
  end

  assign acc = (ramstate == RAM_ACCESS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      r       <= '0;
      own     <= '0;
      dptr    <= '0;
      iptr    <= '0;
      cnt     <= '0;
      snooped <= 1'b0;
    end else begin
      state   <= state_n;
      r       <= r_n;
      own     <= own_n;
      dptr    <= dptr_n;
      iptr    <= iptr_n;
      cnt     <= cnt_n;
      snooped <= snooped_n;
    end
  end

  always_comb begin
    state_n   = state;
    r_n       = r;
    own_n     = own;
    dptr_n    = dptr;
    iptr_n    = iptr;
    cnt_n     = cnt;
    snooped_n = snooped;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      IDLE: begin
        snooped_n = 1'b0;
        cnt_n     = '0;
        if (|dWEN) begin
          r_n     = rr_pick(dWEN, dptr);
          state_n = WB;
        end else if (|dREN) begin
          r_n = rr_pick(dREN, dptr);
          if (cctrans[r_n]) begin
            state_n   = SNOOP;
            snooped_n = 1'b1;
          end else begin
            state_n = DREAD;
          end
        end else if (|iREN) begin
          r_n     = rr_pick(iREN, iptr);
          state_n = IFETCH;
        end
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = da[r];
        ramstore = ds[r];
        if (acc) begin
          state_n = IDLE;
          dptr_n  = inc(r);
        end
      end
      SNOOP: begin
        if (cnt == CNT_LAST) state_n = RESP;
        else                 cnt_n   = cnt + 3'd1;
      end
      RESP: begin
        // descending scan so the lowest-index matching owner wins
        state_n = DREAD;
        for (int k = CPUS - 1; k >= 0; k--) begin
          if (k != int'(r) && dWEN[k] && da[k] == da[r]) begin
            own_n   = IW'(k);
            state_n = C2C;
          end
        end
      end
      C2C: begin
        ramWEN   = 1'b1;
        ramaddr  = da[own];
        ramstore = ds[own];
        if (acc) begin
          state_n = IDLE;
          dptr_n  = inc(r);
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = da[r];
        if (acc) begin
          state_n = IDLE;
          dptr_n  = inc(r);
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = ia[r];
        if (acc) begin
          state_n = IDLE;
          iptr_n  = inc(r);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // per-lane strobes; snoop outputs stay up through a snooped DREAD
  always_comb begin
    fetch_done = '0;
    data_done  = '0;
    data_take  = '0;
    snoop      = '0;
    snoop_end  = '0;
    snoop_on   = (state == SNOOP) || (state == RESP) || (state == C2C) ||
                 (state == DREAD && snooped);
    for (int k = 0; k < CPUS; k++) begin
      fetch_done[k] = (state == IFETCH) && acc && (k == int'(r));
      data_done[k]  = acc && ((((state == WB) || (state == DREAD)) && (k == int'(r))) ||
                              ((state == C2C) && ((k == int'(r)) || (k == int'(own)))));
      data_take[k]  = (k == int'(r)) && (((state == DREAD) && acc) || (state == C2C));
      snoop[k]      = snoop_on && (k != int'(r));
      snoop_end[k]  = snoop_on && (k != int'(r)) && acc &&
                      ((state == C2C) || (state == DREAD));
    end
  end

  assign load_data = (state == C2C) ? ds[own] : ramload;

  for (genvar g = 0; g < CPUS; g++) begin : g_lane
    coherence_bus_lane #(.WORD_W(WORD_W)) u_lane (
      .clk        (CLK),
      .rst        (RST),
      .fetch_done (fetch_done[g]),
      .data_done  (data_done[g]),
      .data_take  (data_take[g]),
      .snoop      (snoop[g]),
      .inv        (ccwrite[r]),
      .snoop_end  (snoop_end[g]),
      .ram_data   (ramload),
      .load_data  (load_data),
      .snoop_addr (da[r]),
      .iwait      (iwait[g]),
      .dwait      (dwait[g]),
      .iload      (iload[g*WORD_W +: WORD_W]),
      .dload      (dload[g*WORD_W +: WORD_W]),
      .ccwait     (ccwait[g]),
      .ccinv      (ccinv[g]),
      .ccdone     (ccdone[g]),
      .ccsnoopaddr(ccsnoopaddr[g*WORD_W +: WORD_W])
    );
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl (4 CPUs, 2-cycle snoop window).

module tb_coherence_bus_ctrl;
  localparam int CPUS = 4;
  localparam int WORD_W = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

  logic CLK, RST;
  logic [CPUS-1:0] iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv, ccdone;
  logic [CPUS-1:0][WORD_W-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic [WORD_W-1:0] ramload, ramaddr, ramstore;
  logic [1:0] ramstate;
  logic ramREN, ramWEN;

  int n_cmp = 0;
  int n_err = 0;

  coherence_bus_ctrl #(.CPUS(CPUS), .WORD_W(WORD_W), .SNOOP_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ccdone(ccdone),
    .ramload(ramload), .ramstate(ramstate), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // inputs change 1ns after the edge, outputs are sampled 2ns later
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #3;
    chk("rst_iwait", iwait, 4'hF);
    chk("rst_dwait", dwait, 4'hF);
    chk("rst_cc", {ccwait, ccinv, ccdone}, 12'h0);
    chk("rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 66'h0);
    nxt();
    RST = 1'b0;

    // single fetch with two BUSY cycles
    iREN[1] = 1'b1; iaddr[1] = 32'h100;
    settle();
    chk("if_idle_ren", ramREN, 1'b0);
    nxt(); ramstate = BUSY; settle();
    chk("if_busy1", {ramREN, ramaddr}, {1'b1, 32'h100});
    chk("if_busy1_wait", iwait, 4'hF);
    nxt(); settle();
    chk("if_busy2", {ramREN, ramaddr}, {1'b1, 32'h100});
    nxt(); ramstate = ACCESS; ramload = 32'hDEADBEEF; settle();
    chk("if_done_wait", iwait, 4'b1101);
    chk("if_done_load", iload[1], 32'hDEADBEEF);
    nxt(); iREN = '0; ramstate = FREE; ramload = '0; settle();
    chk("if_after_wait", iwait, 4'hF);
    chk("if_hold_load", iload[1], 32'hDEADBEEF);
    chk("if_after_ren", ramREN, 1'b0);

    // writeback beats a same-cycle fetch
    dWEN[0] = 1'b1; daddr[0] = 32'h10; dstore[0] = 32'hAA55;
    iREN[1] = 1'b1; iaddr[1] = 32'h104;
    nxt(); ramstate = ACCESS; settle();
    chk("pri_wb", {ramWEN, ramREN, ramaddr, ramstore}, {2'b10, 32'h10, 32'hAA55});
    chk("pri_wb_dwait", dwait, 4'b1110);
    chk("pri_wb_iwait", iwait, 4'hF);
    nxt(); dWEN = '0; settle();
    chk("pri_gap", {ramREN, ramWEN, iwait}, {2'b00, 4'hF});
    nxt(); ramload = 32'h5555; settle();
    chk("pri_if", {ramREN, ramaddr}, {1'b1, 32'h104});
    chk("pri_if_done", {iwait, iload[1]}, {4'b1101, 32'h5555});
    nxt(); iREN = '0; ramstate = FREE; settle();

    // reset during a read after one BUSY cycle (dptr is 1 here, picks CPU3)
    dREN[3] = 1'b1; daddr[3] = 32'h500;
    nxt(); ramstate = BUSY; settle();
    chk("rstm_read", {ramREN, ramaddr}, {1'b1, 32'h500});
    nxt(); ramstate = ACCESS; ramload = 32'h77; RST = 1'b1; settle();
    chk("rstm_ram", {ramREN, ramWEN, ramaddr}, {2'b00, 32'h0});
    chk("rstm_dwait", dwait, 4'hF);
    chk("rstm_loads", {iload[1], dload[3]}, 64'h0);
    dREN = '0; ramstate = FREE;
    nxt(); RST = 1'b0; settle();
    chk("rstm_idle", {ramREN, dwait}, {1'b0, 4'hF});

    // round-robin between two continuous readers, pointers back at 0
    dREN[0] = 1'b1; dREN[1] = 1'b1; daddr[0] = 32'h200; daddr[1] = 32'h300;
    ramstate = ACCESS;
    for (int t = 0; t < 8; t++) begin
      nxt(); ramload = 32'h1000 + t; settle();
      chk("rr_dwait", dwait, (t % 2 == 0) ? 4'b1110 : 4'b1101);
      chk("rr_addr", ramaddr, (t % 2 == 0) ? 32'h200 : 32'h300);
      chk("rr_load", dload[t % 2], 32'h1000 + t);
      nxt();
      if (t == 7) dREN = '0;
      settle();
      chk("rr_idle", dwait, 4'hF);
    end
    ramstate = FREE;

    // cache-to-cache: CPU0 reads 0x40, CPU1 owns it
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h40;
    nxt(); settle();
    chk("c2c_snp1", {ccwait, ccinv}, {4'b1110, 4'b0000});
    chk("c2c_saddr", ccsnoopaddr[1], 32'h40);
    chk("c2c_snp1_ram", {ramREN, ramWEN, dwait}, {2'b00, 4'hF});
    nxt(); dWEN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'h1234; settle();
    chk("c2c_snp2", ccwait, 4'b1110);
    nxt(); ramstate = BUSY; settle();
    chk("c2c_resp", {ccwait, ramWEN}, {4'b1110, 1'b0});
    nxt(); settle();
    chk("c2c_ram", {ramWEN, ramaddr, ramstore}, {1'b1, 32'h40, 32'h1234});
    chk("c2c_fwd", dload[0], 32'h1234);
    chk("c2c_busy", {dwait, ccdone}, {4'hF, 4'h0});
    nxt(); ramstate = ACCESS; settle();
    chk("c2c_done", {dwait, ccdone, ccwait}, {4'b1100, 4'b1110, 4'b1110});
    nxt(); dREN = '0; dWEN = '0; cctrans = '0; ramstate = FREE; settle();
    chk("c2c_after", {ccwait, ccdone, dwait}, {4'h0, 4'h0, 4'hF});
    chk("c2c_hold", dload[0], 32'h1234);

    // invalidating read miss from CPU2
    dREN[2] = 1'b1; cctrans[2] = 1'b1; ccwrite[2] = 1'b1; daddr[2] = 32'h80;
    nxt(); settle();
    chk("inv_snp", {ccwait, ccinv}, {4'b1011, 4'b1011});
    chk("inv_saddr", ccsnoopaddr[3], 32'h80);
    nxt(); nxt(); ramstate = BUSY; settle();
    chk("inv_resp", ccinv, 4'b1011);
    nxt(); settle();
    chk("inv_read", {ramREN, ramaddr, ccinv, ccdone}, {1'b1, 32'h80, 4'b1011, 4'h0});
    nxt(); ramstate = ACCESS; ramload = 32'hCAFE0080; settle();
    chk("inv_done", {dwait, ccdone}, {4'b1011, 4'b1011});
    chk("inv_load", dload[2], 32'hCAFE0080);
    nxt(); dREN = '0; cctrans = '0; ccwrite = '0; ramstate = FREE; settle();
    chk("inv_after", {ccinv, ccwait, ccdone, dwait}, {4'h0, 4'h0, 4'h0, 4'hF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
